// File: rtl/mips_dmem_arbiter.sv
// Round-robin arbiter between the CPU data port (r0) and a debug/preload port (r1)
// for the single-port data memory, with a per-owner burst limit and 1-cycle read return.
module mips_dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          r0_read,
  input  logic          r0_write,
  input  logic [AW-1:0] r0_address,
  input  logic [DW-1:0] r0_writedata,
  input  logic          r1_read,
  input  logic          r1_write,
  input  logic [AW-1:0] r1_address,
  input  logic [DW-1:0] r1_writedata,
  output logic          r0_wait,
  output logic          r1_wait,
  output logic [DW-1:0] r0_readdata,
  output logic [DW-1:0] r1_readdata,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [AW-1:0] data_address,
  output logic          data_write,
  output logic          data_read,
  output logic [DW-1:0] data_writedata,
  input  logic [DW-1:0] data_readdata,
  output logic          err
);

  localparam logic [3:0] MAXB = MAX_BURST[3:0];

  logic          r_owner;
  logic          r_last;
  logic [3:0]    r_burst;
  logic          r_pend_rd;
  logic          r_pend_id;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rd0;
  logic [DW-1:0] r_rd1;

  logic          w_owner_nxt;
  logic          w_last_nxt;
  logic [3:0]    w_burst_nxt;
  logic          w_pend_rd_nxt;
  logic          w_pend_id_nxt;
  logic          w_err_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_wdata_nxt;
  logic [DW-1:0] w_rd0_nxt;
  logic [DW-1:0] w_rd1_nxt;

  logic          w_req0;
  logic          w_req1;
  logic          w_active;
  logic          w_any;
  logic          w_gnt;
  logic          w_g_read;
  logic          w_g_write;
  logic [AW-1:0] w_g_addr;
  logic [DW-1:0] w_g_wdata;
  logic          w_illegal;

  // Reset is folded into the grant so that no access leaks out while it is asserted.
  assign w_req0    = r0_read | r0_write;
  assign w_req1    = r1_read | r1_write;
  assign w_active  = clk_enable & reset;
  assign w_any     = w_active & (w_req0 | w_req1);
  assign w_illegal = (r0_read & r0_write) | (r1_read & r1_write);

  always_comb begin
    w_gnt = 1'b0;
    if (w_req0 && !w_req1) begin
      w_gnt = 1'b0;
    end else if (w_req1 && !w_req0) begin
      w_gnt = 1'b1;
    end else if (w_req0 && w_req1) begin
      if (r_burst == 4'd0)
        w_gnt = ~r_last;
      else if (r_burst < MAXB)
        w_gnt = r_owner;
      else
        w_gnt = ~r_owner;
    end
  end

  // Read+write together from one requester is serviced as a write.
  always_comb begin
    if (w_gnt) begin
      w_g_read  = r1_read & ~r1_write;
      w_g_write = r1_write;
      w_g_addr  = r1_address;
      w_g_wdata = r1_writedata;
    end else begin
      w_g_read  = r0_read & ~r0_write;
      w_g_write = r0_write;
      w_g_addr  = r0_address;
      w_g_wdata = r0_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_burst   <= 4'd0;
      r_pend_rd <= 1'b0;
      r_pend_id <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd0     <= '0;
      r_rd1     <= '0;
    end else begin
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_burst   <= w_burst_nxt;
      r_pend_rd <= w_pend_rd_nxt;
      r_pend_id <= w_pend_id_nxt;
      r_err     <= w_err_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rd0     <= w_rd0_nxt;
      r_rd1     <= w_rd1_nxt;
    end
  end

  always_comb begin
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_burst_nxt   = r_burst;
    w_pend_rd_nxt = 1'b0;
    w_pend_id_nxt = r_pend_id;
    w_err_nxt     = r_err;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rd0_nxt     = r_rd0;
    w_rd1_nxt     = r_rd1;
    // A response owed from the previous cycle is delivered even while frozen.
    if (r_pend_rd) begin
      if (r_pend_id)
        w_rd1_nxt = data_readdata;
      else
        w_rd0_nxt = data_readdata;
    end
    if (clk_enable) begin
      if (w_illegal)
        w_err_nxt = 1'b1;
      if (w_any) begin
        if (w_gnt == r_owner) begin
          w_burst_nxt = (r_burst >= MAXB) ? MAXB : r_burst + 4'd1;
        end else begin
          w_owner_nxt = w_gnt;
          w_burst_nxt = 4'd1;
        end
        w_last_nxt  = w_gnt;
        w_addr_nxt  = w_g_addr;
        w_wdata_nxt = w_g_wdata;
        if (w_g_read) begin
          w_pend_rd_nxt = 1'b1;
          w_pend_id_nxt = w_gnt;
        end
      end else begin
        w_burst_nxt = 4'd0;
      end
    end
  end

  always_comb begin
    r0_wait        = ~(w_any & ~w_gnt);
    r1_wait        = ~(w_any & w_gnt);
    data_read      = w_any & w_g_read;
    data_write     = w_any & w_g_write;
    data_address   = w_any ? w_g_addr : r_addr;
    data_writedata = w_any ? w_g_wdata : r_wdata;
    r0_rvalid      = r_pend_rd & ~r_pend_id;
    r1_rvalid      = r_pend_rd & r_pend_id;
    r0_readdata    = r0_rvalid ? data_readdata : r_rd0;
    r1_readdata    = r1_rvalid ? data_readdata : r_rd1;
    err            = r_err;
  end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Directed bench for mips_dmem_arbiter with a small synchronous memory model
// whose unwritten words read back as 0xC0DE0000 | address[7:0].
module tb_mips_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_address, r0_writedata, r1_address, r1_writedata;
  logic        r0_wait, r1_wait, r0_rvalid, r1_rvalid;
  logic [31:0] r0_readdata, r1_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read, err;

  int n_checks = 0;
  int n_fail   = 0;

  mips_dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .r0_read(r0_read), .r0_write(r0_write), .r0_address(r0_address), .r0_writedata(r0_writedata),
    .r1_read(r1_read), .r1_write(r1_write), .r1_address(r1_address), .r1_writedata(r1_writedata),
    .r0_wait(r0_wait), .r1_wait(r1_wait), .r0_readdata(r0_readdata), .r1_readdata(r1_readdata),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: registered read, frozen when clk_enable is low.
  logic [31:0] mem_w [0:63];
  logic [63:0] mem_v;
  always @(posedge clk) begin
    if (!reset) begin
      mem_v <= '0;
    end else if (clk_enable) begin
      if (data_write) begin
        mem_w[data_address[7:2]] <= data_writedata;
        mem_v[data_address[7:2]] <= 1'b1;
      end
      if (data_read)
        data_readdata <= mem_v[data_address[7:2]] ? mem_w[data_address[7:2]]
                                                  : (32'hC0DE0000 | {24'b0, data_address[7:0]});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
  endtask

  initial begin
    logic       exp_g;
    logic       prev_g;
    logic [3:0] i4;
    reset = 1'b0; clk_enable = 1'b1;
    clear_req();
    r0_address = 32'h40; r0_writedata = 32'h0; r1_address = 32'h0; r1_writedata = 32'h0;
    r0_read = 1'b1;

    // Reset held with a pending r0 request.
    tick(); tick();
    chk("rst_r0_wait", {31'b0, r0_wait}, 32'd1);
    chk("rst_r1_wait", {31'b0, r1_wait}, 32'd1);
    chk("rst_data_read", {31'b0, data_read}, 32'd0);
    chk("rst_data_addr", data_address, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    chk("rst_r0_readdata", r0_readdata, 32'h0);

    reset = 1'b1;
    #1;
    chk("rel_r0_wait", {31'b0, r0_wait}, 32'd0);
    chk("rel_data_addr", data_address, 32'h40);
    chk("rel_data_read", {31'b0, data_read}, 32'd1);
    tick();
    r0_read = 1'b0;
    #1;
    chk("rel_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    chk("rel_r0_rdata", r0_readdata, 32'hC0DE0040);
    chk("rel_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
    tick();

    // Single owner: r1 writes, r0 reads it back.
    r1_write = 1'b1; r1_address = 32'h10; r1_writedata = 32'hDEADBEEF;
    #1;
    chk("so_r1_wait", {31'b0, r1_wait}, 32'd0);
    chk("so_data_write", {31'b0, data_write}, 32'd1);
    chk("so_data_addr", data_address, 32'h10);
    chk("so_data_wdata", data_writedata, 32'hDEADBEEF);
    tick();
    r1_write = 1'b0; r0_read = 1'b1; r0_address = 32'h10;
    #1;
    chk("so_r0_wait", {31'b0, r0_wait}, 32'd0);
    chk("so_data_read", {31'b0, data_read}, 32'd1);
    chk("so_r0_rvalid_early", {31'b0, r0_rvalid}, 32'd0);
    tick();
    r0_read = 1'b0;
    #1;
    chk("so_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    chk("so_r0_rdata", r0_readdata, 32'hDEADBEEF);
    chk("so_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
    tick();
    chk("so_r0_rvalid_once", {31'b0, r0_rvalid}, 32'd0);
    chk("so_r0_rdata_hold", r0_readdata, 32'hDEADBEEF);
    chk("so_idle_read", {31'b0, data_read}, 32'd0);
    chk("so_idle_addr_hold", data_address, 32'h10);
    chk("so_r1_rvalid2", {31'b0, r1_rvalid}, 32'd0);

    // Contention from reset: expect r0 x4, r1 x4, r0 x4.
    reset = 1'b0; #2; reset = 1'b1;
    r0_read = 1'b1; r0_address = 32'h30;
    r1_read = 1'b1; r1_address = 32'h34;
    prev_g = 1'b0;
    for (int i = 0; i < 12; i++) begin
      i4 = i[3:0];
      exp_g = i4[2];
      #1;
      chk($sformatf("ct_r0_wait_%0d", i), {31'b0, r0_wait}, {31'b0, exp_g});
      chk($sformatf("ct_r1_wait_%0d", i), {31'b0, r1_wait}, {31'b0, ~exp_g});
      chk($sformatf("ct_addr_%0d", i), data_address, exp_g ? 32'h34 : 32'h30);
      if (i > 0) begin
        chk($sformatf("ct_r0_rvalid_%0d", i), {31'b0, r0_rvalid}, {31'b0, ~prev_g});
        chk($sformatf("ct_r1_rvalid_%0d", i), {31'b0, r1_rvalid}, {31'b0, prev_g});
        if (prev_g)
          chk($sformatf("ct_r1_rdata_%0d", i), r1_readdata, 32'hC0DE0034);
        else
          chk($sformatf("ct_r0_rdata_%0d", i), r0_readdata, 32'hC0DE0030);
      end
      prev_g = exp_g;
      tick();
    end
    clear_req();
    #1;
    chk("ct_tail_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    chk("ct_tail_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
    tick();

    // Freeze during an r0 burst of 2.
    reset = 1'b0; #2; reset = 1'b1;
    r0_read = 1'b1; r0_address = 32'h30;
    r1_read = 1'b1; r1_address = 32'h34;
    #1;
    chk("fz_a_r0_wait", {31'b0, r0_wait}, 32'd0);
    tick();
    chk("fz_b_r0_wait", {31'b0, r0_wait}, 32'd0);
    chk("fz_b_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    tick();
    clk_enable = 1'b0;
    #1;
    chk("fz_1_r0_wait", {31'b0, r0_wait}, 32'd1);
    chk("fz_1_r1_wait", {31'b0, r1_wait}, 32'd1);
    chk("fz_1_data_read", {31'b0, data_read}, 32'd0);
    chk("fz_1_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    chk("fz_1_r0_rdata", r0_readdata, 32'hC0DE0030);
    tick();
    chk("fz_2_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    chk("fz_2_r0_wait", {31'b0, r0_wait}, 32'd1);
    chk("fz_2_data_read", {31'b0, data_read}, 32'd0);
    tick();
    chk("fz_3_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    chk("fz_3_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
    tick();
    clk_enable = 1'b1;
    #1;
    chk("fz_c_r0_wait", {31'b0, r0_wait}, 32'd0);
    chk("fz_c_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    tick();
    chk("fz_d_r0_wait", {31'b0, r0_wait}, 32'd0);
    chk("fz_d_r0_rvalid", {31'b0, r0_rvalid}, 32'd1);
    tick();
    chk("fz_e_r0_wait", {31'b0, r0_wait}, 32'd1);
    chk("fz_e_r1_wait", {31'b0, r1_wait}, 32'd0);
    clear_req();
    tick();

    // Illegal read+write from r0 is treated as a write and sets err.
    r0_read = 1'b1; r0_write = 1'b1; r0_address = 32'h20; r0_writedata = 32'h12345678;
    #1;
    chk("il_data_write", {31'b0, data_write}, 32'd1);
    chk("il_data_read", {31'b0, data_read}, 32'd0);
    chk("il_data_wdata", data_writedata, 32'h12345678);
    chk("il_err_before", {31'b0, err}, 32'd0);
    tick();
    r0_write = 1'b0;
    #1;
    chk("il_err_set", {31'b0, err}, 32'd1);
    tick();
    r0_read = 1'b0;
    #1;
    chk("il_rdback_rvalid", {31'b0, r0_rvalid}, 32'd1);
    chk("il_rdback_rdata", r0_readdata, 32'h12345678);
    tick(); tick();
    chk("il_err_sticky", {31'b0, err}, 32'd1);
    reset = 1'b0;
    #1;
    chk("il_err_cleared", {31'b0, err}, 32'd0);
    tick();
    reset = 1'b1;

    // Async reset between accept and response edges drops the read.
    r0_read = 1'b1; r0_address = 32'h30;
    #1;
    chk("ar_r0_wait", {31'b0, r0_wait}, 32'd0);
    tick();
    r0_read = 1'b0;
    reset = 1'b0;
    #1;
    chk("ar_r0_rvalid_rst", {31'b0, r0_rvalid}, 32'd0);
    reset = 1'b1;
    #1;
    chk("ar_r0_rvalid_rel", {31'b0, r0_rvalid}, 32'd0);
    chk("ar_r1_rvalid_rel", {31'b0, r1_rvalid}, 32'd0);
    tick();
    chk("ar_r0_rvalid_next", {31'b0, r0_rvalid}, 32'd0);
    chk("ar_r1_rvalid_next", {31'b0, r1_rvalid}, 32'd0);
    chk("ar_r0_rdata_clr", r0_readdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
